// File: rtl/wr_ptr_level_handler.sv
// rtl/wr_ptr_level_handler.sv - write-domain pointer, level and flag controller for the async FIFO
module wr_ptr_level_handler #(
    parameter int ADDR_WIDTH   = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr_en,
    input  logic                  i_ovf_clr,
    input  logic [ADDR_WIDTH:0]   i_g_rd_ptr,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic                  o_wr_ack,
    output logic [ADDR_WIDTH:0]   o_g_wr_ptr,
    output logic                  o_full,
    output logic                  o_almost_full,
    output logic [ADDR_WIDTH:0]   o_level,
    output logic [ADDR_WIDTH:0]   o_free,
    output logic                  o_overflow
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH_L = PW'(2 ** ADDR_WIDTH);
    localparam logic [PW-1:0] AFULL_L = PW'(AFULL_THRESH);

    logic [PW-1:0] b_ptr_q, b_ptr_d;
    logic [PW-1:0] g_ptr_q, g_ptr_d;
    logic [PW-1:0] level_q, level_d;
    logic [PW-1:0] free_q, free_d;
    logic          full_q, full_d;
    logic          afull_q, afull_d;
    logic          ovf_q, ovf_d;
    logic [PW-1:0] rd_bin;
    logic          wr_ack;

    assign wr_ack = i_wr_en & ~full_q & ~i_rst;

    // Each binary bit is the XOR of its Gray bit and every Gray bit above it.
    always_comb begin
        rd_bin = '0;
        for (int i = 0; i < PW; i++) begin
            rd_bin[i] = ^(i_g_rd_ptr >> i);
        end
    end

    always_comb begin
        b_ptr_d = b_ptr_q + {{(PW-1){1'b0}}, wr_ack};
        g_ptr_d = b_ptr_d ^ (b_ptr_d >> 1);
        level_d = b_ptr_d - rd_bin;
        free_d  = DEPTH_L - level_d;
        full_d  = (level_d == DEPTH_L);
        afull_d = (level_d >= AFULL_L);
        // A set in the same cycle as a clear wins so no overflow event is lost.
        ovf_d   = (ovf_q & ~i_ovf_clr) | (i_wr_en & full_q);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            b_ptr_q <= '0;
            g_ptr_q <= '0;
            level_q <= '0;
            free_q  <= DEPTH_L;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            b_ptr_q <= b_ptr_d;
            g_ptr_q <= g_ptr_d;
            level_q <= level_d;
            free_q  <= free_d;
            full_q  <= full_d;
            afull_q <= afull_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_wr_addr     = b_ptr_q[ADDR_WIDTH-1:0];
    assign o_wr_ack      = wr_ack;
    assign o_g_wr_ptr    = g_ptr_q;
    assign o_full        = full_q;
    assign o_almost_full = afull_q;
    assign o_level       = level_q;
    assign o_free        = free_q;
    assign o_overflow    = ovf_q;

endmodule

// File: tb/tb_wr_ptr_level_handler.sv
// tb/tb_wr_ptr_level_handler.sv - scoreboard bench for wr_ptr_level_handler
module tb_wr_ptr_level_handler;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int PMOD  = 32;
    localparam int AF    = 12;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_wr_en = 1'b0;
    logic          i_ovf_clr = 1'b0;
    logic [AW:0]   i_g_rd_ptr = '0;
    logic [AW-1:0] o_wr_addr;
    logic          o_wr_ack;
    logic [AW:0]   o_g_wr_ptr;
    logic          o_full;
    logic          o_almost_full;
    logic [AW:0]   o_level;
    logic [AW:0]   o_free;
    logic          o_overflow;

    wr_ptr_level_handler #(.ADDR_WIDTH(AW), .AFULL_THRESH(AF)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_wr_en(i_wr_en), .i_ovf_clr(i_ovf_clr),
        .i_g_rd_ptr(i_g_rd_ptr), .o_wr_addr(o_wr_addr), .o_wr_ack(o_wr_ack),
        .o_g_wr_ptr(o_g_wr_ptr), .o_full(o_full), .o_almost_full(o_almost_full),
        .o_level(o_level), .o_free(o_free), .o_overflow(o_overflow)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int ack;
        int addr;
        int gptr;
        int full;
        int afull;
        int level;
        int free;
        int ovf;
    } exp_t;

    exp_t sb_q[$];
    int checks = 0;
    int errors = 0;

    // Reference state: write pointer as a plain integer count modulo 2*DEPTH.
    int m_wp = 0;
    int m_rd = 0;
    int m_full = 0;
    int m_ovf = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic int to_gray(input int b);
        return b ^ (b >> 1);
    endfunction

    // Drive one cycle (called at a falling edge) and queue the expected result.
    task automatic step(input bit wr, input bit clr, input bit rst, input int rd);
        exp_t e;
        int lvl;
        i_wr_en    = wr;
        i_ovf_clr  = clr;
        i_rst      = rst;
        m_rd       = rd % PMOD;
        i_g_rd_ptr = (AW+1)'(to_gray(m_rd));
        e.ack  = (wr && !m_full && !rst) ? 1 : 0;
        e.addr = m_wp % DEPTH;
        if (rst) begin
            m_wp = 0; m_full = 0; m_ovf = 0; lvl = 0;
        end else begin
            m_ovf = ((m_ovf != 0 && !clr) || (wr && m_full != 0)) ? 1 : 0;
            m_wp  = (m_wp + e.ack) % PMOD;
            lvl   = (m_wp - m_rd + PMOD) % PMOD;
            m_full = (lvl == DEPTH) ? 1 : 0;
        end
        e.gptr  = to_gray(m_wp);
        e.full  = m_full;
        e.afull = (lvl >= AF) ? 1 : 0;
        e.level = lvl;
        e.free  = DEPTH - lvl;
        e.ovf   = m_ovf;
        sb_q.push_back(e);
        @(negedge i_clk);
    endtask

    // Monitor: combinational outputs just before the edge, registered ones just after.
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            #4;
            if (sb_q.size() != 0) begin
                e = sb_q[0];
                chk("wr_ack", int'(o_wr_ack), e.ack);
                if (e.ack != 0) chk("wr_addr", int'(o_wr_addr), e.addr);
                @(posedge i_clk);
                #1;
                e = sb_q.pop_front();
                chk("g_wr_ptr", int'(o_g_wr_ptr), e.gptr);
                chk("full", int'(o_full), e.full);
                chk("almost_full", int'(o_almost_full), e.afull);
                chk("level", int'(o_level), e.level);
                chk("free", int'(o_free), e.free);
                chk("overflow", int'(o_overflow), e.ovf);
            end
        end
    end

    initial begin
        int n;
        @(negedge i_clk);
        step(1, 0, 1, 0);
        // Fill from empty, one rejected write, overflow clear behaviour.
        for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        // Read side advances while full, then a write coinciding with an advance.
        step(0, 0, 0, 3);
        step(1, 0, 0, 4);
        step(0, 0, 0, 4);
        // Mid-operation reset with a write pending.
        step(1, 0, 1, 0);
        for (int i = 0; i < 9; i++) step(1, 0, 0, 0);
        step(1, 0, 1, 0);
        step(0, 0, 0, 0);
        // Wrap with the read pointer trailing by two.
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 40; i++) step(1, 0, 0, m_wp - 1 + PMOD);
        // Almost-full threshold from a fresh reset.
        step(0, 0, 1, 0);
        for (int i = 0; i < 12; i++) step(1, 0, 0, 0);
        // Randomised traffic with legal read-pointer advances.
        for (int i = 0; i < 3000; i++) begin
            bit wr, clr, rst;
            int rd;
            wr  = ($urandom_range(0, 9) < 7);
            clr = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 199) == 0);
            rd  = m_rd;
            if (rst) rd = 0;
            else if (((m_wp - m_rd + PMOD) % PMOD) > 0 && $urandom_range(0, 9) < 5) rd = m_rd + 1;
            step(wr, clr, rst, rd);
        end
        i_wr_en = 0;
        n = 0;
        while (sb_q.size() != 0 && n < 10) begin
            @(negedge i_clk);
            n++;
        end
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
